// File: rtl/fb_lut_pkg.sv
// Shared types for the feedback LUT port-B arbiter: LUT select codes, requester ids,
// FSM states and default LUT geometry.
package fb_lut_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 7;

    typedef enum logic [1:0] {
        SelBpm1I = 2'd0,
        SelBpm1Q = 2'd1,
        SelBpm2I = 2'd2,
        SelBpm2Q = 2'd3
    } lut_sel_e;

    typedef enum logic {
        ReqHost = 1'b0,
        ReqCal  = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2,
        StDone   = 2'd3
    } arb_state_e;

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer moves past the winner whenever a
// grant is taken, so a contested request alternates between host and calibration loader.
module fb_rr_arb2
    import fb_lut_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output req_id_e    winner_o
);

    req_id_e prio_q, prio_d;

    always_comb begin
        winner_o = ReqHost;
        if (req_i == 2'b11) begin
            winner_o = prio_q;
        end else if (req_i[1]) begin
            winner_o = ReqCal;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (update_i && (req_i != 2'b00)) begin
            prio_d = (winner_o == ReqHost) ? ReqCal : ReqHost;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= ReqHost;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fb_lut_arbiter.sv
// Shares LUT port B between the host and the calibration loader, one access in flight.
// Define FB_LUT_WR_COUNT_EN to build the completed-write counter on wr_count.
module fb_lut_arbiter
    import fb_lut_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store_strb,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [1:0]        h_sel,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_din,
    output logic              h_gnt,
    output logic              h_done,
    output logic [DATA_W-1:0] h_dout,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_sel,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_din,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_dout,
    output logic [ADDR_W-1:0] lut_addrb,
    output logic [DATA_W-1:0] lut_dinb,
    output logic [3:0]        lut_web,
    input  logic [DATA_W-1:0] lut_doutb0,
    input  logic [DATA_W-1:0] lut_doutb1,
    input  logic [DATA_W-1:0] lut_doutb2,
    input  logic [DATA_W-1:0] lut_doutb3,
    output logic              locked,
    output logic [15:0]       wr_count
);

    localparam logic [1:0] WaitLast = 2'(RD_LAT - 1);

    arb_state_e        state_q, state_d;
    req_id_e           winner_q, arb_winner;
    logic              we_q;
    logic [1:0]        sel_q;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] lut_addrb_q;
    logic [DATA_W-1:0] lut_dinb_q;
    logic [DATA_W-1:0] h_dout_q, c_dout_q;
    logic [DATA_W-1:0] rd_data;
    logic              h_req_q, c_req_q, locked_q;
    logic [1:0]        req_vec;
    logic              arb_update, rd_capture;

    // A request must be seen on two consecutive cycles; this also ignores the stale
    // req still high in the cycle a requester drops it after done.
    assign req_vec = {c_req & c_req_q, h_req & h_req_q};

    fb_rr_arb2 u_arb (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req_vec),
        .update_i (arb_update),
        .winner_o (arb_winner)
    );

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        arb_update = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!store_strb && (req_vec != 2'b00)) begin
                    arb_update = 1'b1;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                wcnt_d  = 2'd0;
                state_d = we_q ? StDone : StWait;
            end
            StWait: begin
                if (wcnt_q == WaitLast) begin
                    state_d = StDone;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_data = lut_doutb0;
        unique case (sel_q)
            2'd0: rd_data = lut_doutb0;
            2'd1: rd_data = lut_doutb1;
            2'd2: rd_data = lut_doutb2;
            2'd3: rd_data = lut_doutb3;
            default: rd_data = lut_doutb0;
        endcase
    end

    assign rd_capture = (state_q == StWait) && (wcnt_q == WaitLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wcnt_q      <= 2'd0;
            winner_q    <= ReqHost;
            we_q        <= 1'b0;
            sel_q       <= 2'd0;
            lut_addrb_q <= '0;
            lut_dinb_q  <= '0;
            h_dout_q    <= '0;
            c_dout_q    <= '0;
            h_req_q     <= 1'b0;
            c_req_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            h_req_q  <= h_req;
            c_req_q  <= c_req;
            locked_q <= store_strb & (h_req | c_req);
            if (arb_update) begin
                winner_q <= arb_winner;
                if (arb_winner == ReqCal) begin
                    we_q        <= c_we;
                    sel_q       <= c_sel;
                    lut_addrb_q <= c_addr;
                    lut_dinb_q  <= c_din;
                end else begin
                    we_q        <= h_we;
                    sel_q       <= h_sel;
                    lut_addrb_q <= h_addr;
                    lut_dinb_q  <= h_din;
                end
            end
            if (rd_capture) begin
                if (winner_q == ReqCal) begin
                    c_dout_q <= rd_data;
                end else begin
                    h_dout_q <= rd_data;
                end
            end
        end
    end

`ifdef FB_LUT_WR_COUNT_EN
    logic [15:0] wr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= 16'd0;
        end else if ((state_q == StDone) && we_q) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign wr_count = wr_count_q;
`else
    assign wr_count = 16'd0;
`endif

    // Decoded from state so an asynchronous reset clears them immediately.
    assign lut_web   = ((state_q == StAccess) && we_q) ? sel_onehot(sel_q) : 4'b0000;
    assign h_gnt     = (state_q == StAccess) && (winner_q == ReqHost);
    assign c_gnt     = (state_q == StAccess) && (winner_q == ReqCal);
    assign h_done    = (state_q == StDone) && (winner_q == ReqHost);
    assign c_done    = (state_q == StDone) && (winner_q == ReqCal);
    assign h_dout    = h_dout_q;
    assign c_dout    = c_dout_q;
    assign lut_addrb = lut_addrb_q;
    assign lut_dinb  = lut_dinb_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_fb_lut_arbiter.sv
// Directed bench for fb_lut_arbiter: latencies, LUT strobes, round-robin order,
// store_strb lockout and reset abort, all against hand-computed values.
module tb_fb_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        store_strb;
    logic        h_req, h_we, c_req, c_we;
    logic [1:0]  h_sel, c_sel;
    logic [14:0] h_addr, c_addr;
    logic [6:0]  h_din, c_din;
    logic        h_gnt, h_done, c_gnt, c_done;
    logic [6:0]  h_dout, c_dout;
    logic [14:0] lut_addrb;
    logic [6:0]  lut_dinb;
    logic [3:0]  lut_web;
    logic [6:0]  lut_doutb0, lut_doutb1, lut_doutb2, lut_doutb3;
    logic        locked;
    logic [15:0] wr_count;

    int n_chk = 0;
    int n_bad = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    fb_lut_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .store_strb (store_strb),
        .h_req      (h_req),
        .h_we       (h_we),
        .h_sel      (h_sel),
        .h_addr     (h_addr),
        .h_din      (h_din),
        .h_gnt      (h_gnt),
        .h_done     (h_done),
        .h_dout     (h_dout),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_sel      (c_sel),
        .c_addr     (c_addr),
        .c_din      (c_din),
        .c_gnt      (c_gnt),
        .c_done     (c_done),
        .c_dout     (c_dout),
        .lut_addrb  (lut_addrb),
        .lut_dinb   (lut_dinb),
        .lut_web    (lut_web),
        .lut_doutb0 (lut_doutb0),
        .lut_doutb1 (lut_doutb1),
        .lut_doutb2 (lut_doutb2),
        .lut_doutb3 (lut_doutb3),
        .locked     (locked),
        .wr_count   (wr_count)
    );

    always @(negedge clk) begin
        if ((h_gnt && c_gnt) || (h_done && c_done)) overlap_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is at cycle 0 with the DUT idle; cycle numbers are relative to that point.
    task automatic xact(input bit cal, input bit we, input logic [1:0] sel,
                        input logic [14:0] addr, input logic [6:0] din,
                        output int gnt_cyc, output int done_cyc, output logic [3:0] web_seen,
                        output logic [14:0] addr_seen, output logic [6:0] din_seen,
                        output int foreign);
        gnt_cyc  = -1;
        done_cyc = -1;
        web_seen = 4'b0;
        addr_seen = '0;
        din_seen = '0;
        foreign  = 0;
        if (cal) begin
            c_req = 1'b1; c_we = we; c_sel = sel; c_addr = addr; c_din = din;
        end else begin
            h_req = 1'b1; h_we = we; h_sel = sel; h_addr = addr; h_din = din;
        end
        for (int t = 1; t <= 20 && done_cyc < 0; t++) begin
            tick();
            if ((cal ? c_gnt : h_gnt) && gnt_cyc < 0) gnt_cyc = t;
            if (cal ? (h_gnt || h_done) : (c_gnt || c_done)) foreign++;
            if (lut_web != 4'b0) begin
                web_seen  = lut_web;
                addr_seen = lut_addrb;
                din_seen  = lut_dinb;
            end
            if (cal ? c_done : h_done) done_cyc = t;
        end
        tick();
        h_req = 1'b0;
        c_req = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    int          g, d, f, cnt;
    logic [3:0]  w;
    logic [14:0] a;
    logic [6:0]  di;
    logic [15:0] wr_exp;
    int          order [3];
    int          gcyc [3];
    int          ngnt;
    bit          lock_ok, gnt_seen, bad_seen;

    initial begin
        rst_n = 1'b0; store_strb = 1'b0;
        h_req = 0; h_we = 0; h_sel = 0; h_addr = 0; h_din = 0;
        c_req = 0; c_we = 0; c_sel = 0; c_addr = 0; c_din = 0;
        lut_doutb0 = 7'h11; lut_doutb1 = 7'h2A; lut_doutb2 = 7'h33; lut_doutb3 = 7'h4C;
        #1;
        check_eq("rst_gnt_done", 32'({h_gnt, c_gnt, h_done, c_done}), 32'h0);
        check_eq("rst_web", 32'(lut_web), 32'h0);
        check_eq("rst_locked", 32'(locked), 32'h0);
        check_eq("rst_douts", 32'({h_dout, c_dout}), 32'h0);
        check_eq("rst_lut_bus", 32'({lut_addrb, lut_dinb}), 32'h0);
        check_eq("rst_wr_count", 32'(wr_count), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Host write to bpm2_i.
        xact(1'b0, 1'b1, 2'd2, 15'h1234, 7'h55, g, d, w, a, di, f);
        check_eq("hw_gnt_cyc", 32'(g), 32'd2);
        check_eq("hw_done_cyc", 32'(d), 32'd3);
        check_eq("hw_web", 32'(w), 32'b0100);
        check_eq("hw_addr", 32'(a), 32'h1234);
        check_eq("hw_din", 32'(di), 32'h55);
        check_eq("hw_foreign", 32'(f), 32'd0);
`ifdef FB_LUT_WR_COUNT_EN
        wr_exp = 16'd1;
`else
        wr_exp = 16'd0;
`endif
        check_eq("hw_wr_count", 32'(wr_count), 32'(wr_exp));

        // Host read from bpm1_q.
        xact(1'b0, 1'b0, 2'd1, 15'h0042, 7'h00, g, d, w, a, di, f);
        check_eq("hr_done_cyc", 32'(d), 32'd5);
        check_eq("hr_dout", 32'(h_dout), 32'h2A);
        check_eq("hr_web", 32'(w), 32'h0);
        check_eq("hr_addr_bus", 32'(lut_addrb), 32'h0042);

        // Calibration write to bpm1_i; host read data must hold.
        xact(1'b1, 1'b1, 2'd0, 15'h0ABC, 7'h7F, g, d, w, a, di, f);
        check_eq("cw_gnt_cyc", 32'(g), 32'd2);
        check_eq("cw_done_cyc", 32'(d), 32'd3);
        check_eq("cw_web", 32'(w), 32'b0001);
        check_eq("cw_addr", 32'(a), 32'h0ABC);
        check_eq("cw_din", 32'(di), 32'h7F);
        check_eq("cw_h_dout_hold", 32'(h_dout), 32'h2A);
`ifdef FB_LUT_WR_COUNT_EN
        wr_exp = 16'd2;
`else
        wr_exp = 16'd0;
`endif
        check_eq("cw_wr_count", 32'(wr_count), 32'(wr_exp));

        // Calibration read from bpm2_q.
        xact(1'b1, 1'b0, 2'd3, 15'h7FFF, 7'h00, g, d, w, a, di, f);
        check_eq("cr_done_cyc", 32'(d), 32'd5);
        check_eq("cr_dout", 32'(c_dout), 32'h4C);
        check_eq("cr_h_dout_hold", 32'(h_dout), 32'h2A);
        check_eq("cr_foreign", 32'(f), 32'd0);

        // Request withdrawn before grant: nothing issued.
        h_req = 1'b1; h_we = 1'b1; h_sel = 2'd3; h_addr = 15'h0111; h_din = 7'h22;
        tick();
        h_req = 1'b0;
        bad_seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (h_gnt || h_done || lut_web != 4'b0) bad_seen = 1'b1;
        end
        check_eq("drop_no_access", 32'(bad_seen), 32'd0);

        // Contention: both requesters held, host goes first after reset.
        do_reset();
        h_req = 1'b1; h_we = 1'b1; h_sel = 2'd0; h_addr = 15'h0001; h_din = 7'h01;
        c_req = 1'b1; c_we = 1'b1; c_sel = 2'd3; c_addr = 15'h0002; c_din = 7'h02;
        ngnt = 0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (ngnt < 3 && (h_gnt || c_gnt)) begin
                order[ngnt] = c_gnt ? 1 : 0;
                gcyc[ngnt]  = t;
                ngnt++;
            end
        end
        h_req = 1'b0;
        c_req = 1'b0;
        tick();
        tick();
        check_eq("rr_ngnt", 32'(ngnt), 32'd3);
        if (ngnt == 3) begin
            check_eq("rr_first_host", 32'(order[0]), 32'd0);
            check_eq("rr_second_cal", 32'(order[1]), 32'd1);
            check_eq("rr_third_host", 32'(order[2]), 32'd0);
            check_eq("rr_gnt_cycles", 32'({8'(gcyc[0]), 8'(gcyc[1]), 8'(gcyc[2])}),
                     32'h00020508);
        end

        // Lockout while store_strb is high.
        store_strb = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_sel = 2'd1; c_addr = 15'h0333; c_din = 7'h33;
        lock_ok = 1'b1;
        gnt_seen = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) check_eq("lock_cycle1", 32'(locked), 32'd1);
            if (!locked) lock_ok = 1'b0;
            if (h_gnt || c_gnt) gnt_seen = 1'b1;
        end
        check_eq("lock_held", 32'(lock_ok), 32'd1);
        check_eq("lock_no_gnt", 32'(gnt_seen), 32'd0);
        store_strb = 1'b0;
        cnt = 0;
        g = -1;
        for (int t = 1; t <= 2 && g < 0; t++) begin
            tick();
            if (c_gnt) g = t;
            if (t == 1) check_eq("unlock_locked", 32'(locked), 32'd0);
        end
        check_eq("unlock_gnt_cyc", 32'(g), 32'd1);
        d = -1;
        for (int t = 0; t < 6 && d < 0; t++) begin
            tick();
            if (c_done) d = t;
        end
        check_eq("unlock_done", 32'(d), 32'd0);
        tick();
        c_req = 1'b0;
        tick();

        // Reset asserted during WAIT aborts the read.
        h_req = 1'b1; h_we = 1'b0; h_sel = 2'd1; h_addr = 15'h0555; h_din = 7'h00;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("abort_web", 32'(lut_web), 32'h0);
        check_eq("abort_gnt_done", 32'({h_gnt, h_done, c_gnt, c_done}), 32'h0);
        h_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bad_seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (h_done || c_done || h_gnt) bad_seen = 1'b1;
        end
        check_eq("abort_no_done", 32'(bad_seen), 32'd0);
        check_eq("abort_h_dout", 32'(h_dout), 32'h0);
        xact(1'b0, 1'b0, 2'd3, 15'h0666, 7'h00, g, d, w, a, di, f);
        check_eq("post_rst_done_cyc", 32'(d), 32'd5);
        check_eq("post_rst_dout", 32'(h_dout), 32'h4C);

        check_eq("no_overlap", 32'(overlap_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
